// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: four-master round-robin arbiter for an 8-bit slave bus.
// A grant lasts for as long as the owner keeps its request high. When the
// owner releases, the bus passes directly to the next requester with no
// idle cycle in between. The optional per-grant timeout is compiled in by
// defining the macro ARB_TIMEOUT_EN. A timeout revokes the grant, sets the
// sticky timeout_err flag, and masks the revoked master until it drops its
// request.
module data_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mst_req,
  output logic [3:0]  mst_grant,
  input  logic [31:0] mst_addr,
  input  logic [3:0]  mst_wr,
  input  logic [3:0]  mst_rd,
  input  logic [31:0] mst_wdata,
  output logic [7:0]  slv_addr,
  output logic        slv_wr,
  output logic        slv_rd,
  output logic [7:0]  slv_wdata,
  output logic [1:0]  owner,
  output logic        bus_busy,
  input  logic        err_clr,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT0 = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_GRANT2 = 3'd3,
    ST_GRANT3 = 3'd4
  } state_t;

  state_t     state_r;
  logic [1:0] owner_r;
  logic [1:0] last_owner_r;
  logic       owner_req_s;
  logic       revoke_s;
  logic [3:0] mask_s;
  logic [3:0] eligible_s;
  logic       hold_s;
  logic [2:0] pick_s;
  logic       new_grant_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index}. The search starts at last+1 and wraps, so the
  // master in the 'last' position itself is checked last.
  function automatic logic [2:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!res[2] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic state_t grant_state(input logic [1:0] idx);
    state_t st;
    case (idx)
      2'd0:    st = ST_GRANT0;
      2'd1:    st = ST_GRANT1;
      2'd2:    st = ST_GRANT2;
      2'd3:    st = ST_GRANT3;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

  assign owner_req_s = mst_req[owner_r];
  assign owner       = owner_r;
  assign bus_busy    = |mst_grant;

  // Decide whether to keep the current owner or pick the next round-robin
  // winner. A revoked owner is excluded from the search.
  always_comb begin
    eligible_s = mst_req & ~mask_s;
    hold_s     = 1'b0;
    if (state_r != ST_IDLE) begin
      hold_s = owner_req_s & ~revoke_s;
      if (revoke_s) begin
        eligible_s = eligible_s & ~onehot(owner_r);
      end else begin
        eligible_s = eligible_s;
      end
    end else begin
      hold_s = 1'b0;
    end
    pick_s      = pick_rr(eligible_s, last_owner_r);
    new_grant_s = ~hold_s & pick_s[2];
  end

  // Arbitration FSM with a registered one-hot grant and owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      mst_grant    <= 4'b0000;
      owner_r      <= 2'd0;
      last_owner_r <= 2'd3;
    end else if (hold_s) begin
      state_r      <= state_r;
      mst_grant    <= mst_grant;
      owner_r      <= owner_r;
      last_owner_r <= last_owner_r;
    end else if (pick_s[2]) begin
      state_r      <= grant_state(pick_s[1:0]);
      mst_grant    <= onehot(pick_s[1:0]);
      owner_r      <= pick_s[1:0];
      last_owner_r <= pick_s[1:0];
    end else begin
      state_r      <= ST_IDLE;
      mst_grant    <= 4'b0000;
      owner_r      <= owner_r;
      last_owner_r <= last_owner_r;
    end
  end

  // Slave bus mux: forwards the granted master's signals and drives zero when idle.
  always_comb begin
    slv_addr  = 8'h00;
    slv_wr    = 1'b0;
    slv_rd    = 1'b0;
    slv_wdata = 8'h00;
    case (state_r)
      ST_GRANT0, ST_GRANT1, ST_GRANT2, ST_GRANT3: begin
        slv_addr  = mst_addr[8*owner_r +: 8];
        slv_wr    = mst_wr[owner_r];
        slv_rd    = mst_rd[owner_r];
        slv_wdata = mst_wdata[8*owner_r +: 8];
      end
      default: begin
        slv_addr  = 8'h00;
        slv_wr    = 1'b0;
        slv_rd    = 1'b0;
        slv_wdata = 8'h00;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_r;
  logic [3:0] mask_r;
  logic       err_r;

  assign revoke_s    = (state_r != ST_IDLE) && owner_req_s && (cnt_r == CNT_LAST);
  assign mask_s      = mask_r;
  assign timeout_err = err_r;

  // Per-grant cycle counter, revoked-master mask and sticky error flag.
  // When a revoke and err_clr occur in the same cycle, the flag stays set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= 8'd0;
      mask_r <= 4'b0000;
      err_r  <= 1'b0;
    end else begin
      if (new_grant_s) begin
        cnt_r <= 8'd0;
      end else if (hold_s) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
      mask_r <= (mask_r & mst_req) | (revoke_s ? onehot(owner_r) : 4'b0000);
      if (revoke_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end
`else
  logic unused_err_clr_s;

  assign revoke_s         = 1'b0;
  assign mask_s           = 4'b0000;
  assign timeout_err      = 1'b0;
  assign unused_err_clr_s = err_clr;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed testbench for data_bus_arbiter. It is built with TIMEOUT_CYCLES=4.
// The timeout scenario is checked when ARB_TIMEOUT_EN is defined; otherwise
// the bench checks that grants are unbounded.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  mst_req = 4'b0000;
  logic [3:0]  mst_grant;
  logic [31:0] mst_addr = 32'h0;
  logic [3:0]  mst_wr = 4'b0000;
  logic [3:0]  mst_rd = 4'b0000;
  logic [31:0] mst_wdata = 32'h0;
  logic [7:0]  slv_addr;
  logic        slv_wr;
  logic        slv_rd;
  logic [7:0]  slv_wdata;
  logic [1:0]  owner;
  logic        bus_busy;
  logic        err_clr = 1'b0;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  data_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mst_req(mst_req), .mst_grant(mst_grant),
    .mst_addr(mst_addr), .mst_wr(mst_wr), .mst_rd(mst_rd), .mst_wdata(mst_wdata),
    .slv_addr(slv_addr), .slv_wr(slv_wr), .slv_rd(slv_rd), .slv_wdata(slv_wdata),
    .owner(owner), .bus_busy(bus_busy), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input logic [7:0] a, input logic [7:0] d,
                            input logic w, input logic r);
    mst_addr[8*k +: 8]  = a;
    mst_wdata[8*k +: 8] = d;
    mst_wr[k] = w;
    mst_rd[k] = r;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mst_req = 4'b0000;
    err_clr = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if ({mst_grant, owner, bus_busy, slv_addr, slv_wr, timeout_err} !== 17'h0) begin
      $display("FAIL reset_state: got grant=%b owner=%0d busy=%b addr=%h wr=%b err=%b, want all zero",
               mst_grant, owner, bus_busy, slv_addr, slv_wr, timeout_err);
      errors++;
    end
    set_master(0, 8'h11, 8'hA1, 1'b1, 1'b0);
    set_master(1, 8'hEE, 8'hEF, 1'b0, 1'b1);
    rst = 1'b1;
    mst_req = 4'b0001;
    checks++;
    if (mst_grant !== 4'b0000) begin
      $display("FAIL first_latency: got grant=%b before edge, want 0000", mst_grant);
      errors++;
    end
    step();
    checks++;
    if (mst_grant !== 4'b0001 || owner !== 2'd0 || bus_busy !== 1'b1) begin
      $display("FAIL first_grant: got grant=%b owner=%0d busy=%b, want 0001/0/1", mst_grant, owner, bus_busy);
      errors++;
    end
    checks++;
    if (slv_addr !== 8'h11 || slv_wdata !== 8'hA1 || slv_wr !== 1'b1 || slv_rd !== 1'b0) begin
      $display("FAIL first_slave: got addr=%h data=%h wr=%b rd=%b, want 11/a1/1/0", slv_addr, slv_wdata, slv_wr, slv_rd);
      errors++;
    end
    mst_req = 4'b0000;
    step();
    checks++;
    if (mst_grant !== 4'b0000 || owner !== 2'd0 || bus_busy !== 1'b0 || slv_addr !== 8'h00 || slv_wr !== 1'b0) begin
      $display("FAIL idle_after_drop: got grant=%b owner=%0d busy=%b addr=%h wr=%b, want 0000/0/0/00/0",
               mst_grant, owner, bus_busy, slv_addr, slv_wr);
      errors++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx;
    logic [1:0] prev;
    do_reset();
    for (int k = 0; k < 4; k++) set_master(k, 8'h10 + 8'(k), 8'hA0 + 8'(k), 1'b0, k[0]);
    mst_req = 4'b1111;
    prev = 2'd0;
    for (int n = 0; n < 5; n++) begin
      exp_idx = 2'(n % 4);
      for (int c = 0; c < 3; c++) begin
        step();
        if (c == 0 && n > 0) mst_req[prev] = 1'b1;
        checks++;
        if (mst_grant !== (4'b0001 << exp_idx) || owner !== exp_idx) begin
          $display("FAIL rr_order n=%0d c=%0d: got grant=%b owner=%0d, want owner %0d", n, c, mst_grant, owner, exp_idx);
          errors++;
        end
        if (c == 0) begin
          checks++;
          if (slv_addr !== 8'h10 + 8'(exp_idx) || slv_rd !== exp_idx[0]) begin
            $display("FAIL rr_slave n=%0d: got addr=%h rd=%b, want %h/%b", n, slv_addr, slv_rd, 8'h10 + 8'(exp_idx), exp_idx[0]);
            errors++;
          end
        end
      end
      mst_req[exp_idx] = 1'b0;
      prev = exp_idx;
    end
    mst_req = 4'b0000;
    step();
  endtask

  task automatic test_handoff();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      mst_req = 4'b0100;
      step();
      checks++;
      if (mst_grant !== 4'b0100) begin
        $display("FAIL handoff_setup t=%0d: got grant=%b, want 0100", t, mst_grant);
        errors++;
      end
      mst_req = (t == 0) ? 4'b0101 : 4'b1101;
      step();
      mst_req[2] = 1'b0;
      step();
      checks++;
      if (mst_grant !== ((t == 0) ? 4'b0001 : 4'b1000) || owner !== ((t == 0) ? 2'd0 : 2'd3)) begin
        $display("FAIL handoff t=%0d: got grant=%b owner=%0d, want %b", t, mst_grant, owner, (t == 0) ? 4'b0001 : 4'b1000);
        errors++;
      end
      mst_req = 4'b0000;
      step();
      checks++;
      if (mst_grant !== 4'b0000 || owner !== ((t == 0) ? 2'd0 : 2'd3)) begin
        $display("FAIL owner_hold t=%0d: got grant=%b owner=%0d, want idle with owner kept", t, mst_grant, owner);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    set_master(2, 8'h5A, 8'hC3, 1'b1, 1'b0);
    mst_req = 4'b0100;
    step();
    checks++;
    if (mst_grant !== 4'b0100 || slv_wr !== 1'b1 || slv_addr !== 8'h5A) begin
      $display("FAIL mid_write_setup: got grant=%b wr=%b addr=%h, want 0100/1/5a", mst_grant, slv_wr, slv_addr);
      errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mst_grant !== 4'b0000 || slv_wr !== 1'b0 || slv_addr !== 8'h00 || slv_wdata !== 8'h00) begin
      $display("FAIL async_reset: got grant=%b wr=%b addr=%h data=%h, want zeros", mst_grant, slv_wr, slv_addr, slv_wdata);
      errors++;
    end
    #2;
    rst = 1'b1;
    step();
    checks++;
    if (mst_grant !== 4'b0100 || owner !== 2'd2) begin
      $display("FAIL regrant_after_reset: got grant=%b owner=%0d, want 0100/2", mst_grant, owner);
      errors++;
    end
    mst_req = 4'b0000;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    mst_req = 4'b0010;
    step();
    mst_req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mst_grant !== 4'b0010 || timeout_err !== 1'b0) begin
        $display("FAIL timeout_hold c=%0d: got grant=%b err=%b, want 0010/0", c, mst_grant, timeout_err);
        errors++;
      end
      step();
    end
    checks++;
    if (mst_grant !== 4'b0010) begin
      $display("FAIL timeout_last_cycle: got grant=%b, want 0010", mst_grant);
      errors++;
    end
    step();
    checks++;
    if (mst_grant !== 4'b1000 || owner !== 2'd3 || timeout_err !== 1'b1) begin
      $display("FAIL timeout_revoke: got grant=%b owner=%0d err=%b, want 1000/3/1", mst_grant, owner, timeout_err);
      errors++;
    end
    mst_req = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (mst_grant !== 4'b0000 || timeout_err !== 1'b1) begin
        $display("FAIL timeout_mask c=%0d: got grant=%b err=%b, want 0000/1", c, mst_grant, timeout_err);
        errors++;
      end
    end
    mst_req = 4'b0000;
    step();
    mst_req = 4'b0010;
    step();
    checks++;
    if (mst_grant !== 4'b0010) begin
      $display("FAIL timeout_unmask: got grant=%b, want 0010", mst_grant);
      errors++;
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || mst_grant !== 4'b0010) begin
      $display("FAIL err_clear: got err=%b grant=%b, want 0/0010", timeout_err, mst_grant);
      errors++;
    end
    step();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || mst_grant !== 4'b0000) begin
      $display("FAIL set_wins: got err=%b grant=%b, want 1/0000", timeout_err, mst_grant);
      errors++;
    end
    mst_req = 4'b0000;
    step();
  endtask
`else
  task automatic test_timeout();
    do_reset();
    mst_req = 4'b0010;
    step();
    mst_req = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (mst_grant !== 4'b0010 || timeout_err !== 1'b0) begin
        $display("FAIL unbounded_grant c=%0d: got grant=%b err=%b, want 0010/0", c, mst_grant, timeout_err);
        errors++;
      end
      step();
    end
    mst_req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_handoff();
    test_reset_mid_write();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
